br_update_scheduler: RTL and testbench

BR_UPDATE_SCHEDULER -- requirements
Module: br_update_scheduler

---
 rtl/br_update_scheduler_pkg.sv | 26 ++
 rtl/br_update_scheduler_index_conflict.sv | 25 ++
 rtl/br_update_scheduler.sv | 104 ++++++++++
 tb/tb_br_update_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/br_update_scheduler_pkg.sv
// Shared types for the branch-update scheduler: entry layout, PC type, queue depth
// and the predictor index extraction.
`ifndef WAY
`define WAY 2
`endif
`ifndef BR_BUF_IDX_LEN
`define BR_BUF_IDX_LEN 4
`endif

package br_update_scheduler_pkg;
   localparam int unsigned WAY_DFLT       = `WAY;
   localparam int unsigned BR_BUF_IDX_LEN = `BR_BUF_IDX_LEN;
   localparam int unsigned UPD_DEPTH      = 8;

   typedef logic [31:0] PC_t;

   typedef struct packed {
      PC_t  source_pc;
      PC_t  target_pc;
      logic taken;
   } br_upd_entry_t;

   function automatic logic [BR_BUF_IDX_LEN-1:0] br_idx(input PC_t pc);
      return pc[BR_BUF_IDX_LEN-1:0];
   endfunction
endpackage

// File: rtl/br_update_scheduler_index_conflict.sv
// Per-slot withhold mask: a drain slot is held back when its predictor index matches
// an older available slot; once one slot is held, every younger slot is held too.
module br_index_conflict
   import br_update_scheduler_pkg::*;
#(
   parameter int unsigned UPD_WIDTH = 2
) (
   input  logic [UPD_WIDTH-1:0]                     i_avail,
   input  logic [UPD_WIDTH-1:0][BR_BUF_IDX_LEN-1:0] i_idx,
   output logic [UPD_WIDTH-1:0]                     o_withhold
);
   logic w_block;

   always_comb begin
      o_withhold = '0;
      w_block    = 1'b0;
      // w_block is sticky across slots, giving the in-order cut-off for younger slots
      for (int unsigned k = 1; k < UPD_WIDTH; k++) begin
         for (int unsigned j = 0; j < k; j++) begin
            if (i_avail[j] && (i_idx[j] == i_idx[k])) w_block = 1'b1;
         end
         o_withhold[k] = i_avail[k] && w_block;
      end
   end
endmodule

// File: rtl/br_update_scheduler.sv
// Retire-to-predictor update FIFO: compacts retired branch updates into a circular
// queue and drains up to UPD_WIDTH per cycle, avoiding same-index updates in one cycle.
module br_update_scheduler
   import br_update_scheduler_pkg::*;
#(
   parameter int unsigned WAY       = WAY_DFLT,
   parameter int unsigned DEPTH     = UPD_DEPTH,
   parameter int unsigned UPD_WIDTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WAY-1:0]             in_valid,
   input  PC_t  [WAY-1:0]             in_source_pc,
   input  PC_t  [WAY-1:0]             in_target_pc,
   input  logic [WAY-1:0]             in_taken,
   output logic                       in_ready,
   input  logic                       upd_hold,
   output logic [UPD_WIDTH-1:0]       upd_valid,
   output PC_t  [UPD_WIDTH-1:0]       upd_source_pc,
   output PC_t  [UPD_WIDTH-1:0]       upd_target_pc,
   output logic [UPD_WIDTH-1:0]       upd_taken,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                conflict_stalls
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   br_upd_entry_t r_mem [DEPTH];
   logic [PW-1:0] r_head, r_tail;
   logic [CW-1:0] r_count;
   logic [15:0]   r_stalls;

   br_upd_entry_t                            w_cand [UPD_WIDTH];
   logic [UPD_WIDTH-1:0][BR_BUF_IDX_LEN-1:0] w_idx;
   logic [UPD_WIDTH-1:0]                     w_avail, w_withhold, w_grant;
   logic [CW-1:0]                            w_enq_cnt, w_deq_cnt;
   logic [WAY-1:0]                           w_wr_en;
   logic [PW-1:0]                            w_wr_ptr [WAY];
   logic                                     w_ready;

   assign w_ready  = (CW'(DEPTH) - r_count) >= CW'(WAY);
   assign in_ready = reset || w_ready;

   always_comb begin
      for (int unsigned k = 0; k < UPD_WIDTH; k++) begin
         w_cand[k]  = r_mem[r_head + PW'(k)];
         w_idx[k]   = br_idx(w_cand[k].source_pc);
         w_avail[k] = !upd_hold && !reset && (CW'(k) < r_count);
      end
   end

   br_index_conflict #(.UPD_WIDTH(UPD_WIDTH)) u_conflict (
      .i_avail    (w_avail),
      .i_idx      (w_idx),
      .o_withhold (w_withhold)
   );

   assign w_grant = w_avail & ~w_withhold;

   always_comb begin
      w_deq_cnt = '0;
      for (int unsigned k = 0; k < UPD_WIDTH; k++) begin
         upd_valid[k]     = w_grant[k];
         upd_source_pc[k] = w_cand[k].source_pc;
         upd_target_pc[k] = w_cand[k].target_pc;
         upd_taken[k]     = w_cand[k].taken;
         if (w_grant[k]) w_deq_cnt = w_deq_cnt + 1'b1;
      end
   end

   // Lane compaction: each valid lane takes the next free slot after the ones before it
   always_comb begin
      w_enq_cnt = '0;
      for (int unsigned l = 0; l < WAY; l++) begin
         w_wr_en[l]  = w_ready && in_valid[l];
         w_wr_ptr[l] = r_tail + PW'(w_enq_cnt);
         if (w_wr_en[l]) w_enq_cnt = w_enq_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_stalls <= '0;
         for (int unsigned d = 0; d < DEPTH; d++) r_mem[d] <= '0;
      end else begin
         for (int unsigned l = 0; l < WAY; l++) begin
            if (w_wr_en[l])
               r_mem[w_wr_ptr[l]] <= '{source_pc: in_source_pc[l],
                                       target_pc: in_target_pc[l],
                                       taken:     in_taken[l]};
         end
         r_tail  <= r_tail + PW'(w_enq_cnt);
         r_head  <= r_head + PW'(w_deq_cnt);
         r_count <= r_count + w_enq_cnt - w_deq_cnt;
         if ((|w_withhold) && (r_stalls != '1)) r_stalls <= r_stalls + 16'd1;
      end
   end

   assign count           = r_count;
   assign conflict_stalls = r_stalls;
endmodule

// File: tb/tb_br_update_scheduler.sv
// Directed bench for br_update_scheduler (WAY=2, DEPTH=8, UPD_WIDTH=2, 4-bit index).
module tb_br_update_scheduler;
   import br_update_scheduler_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  in_valid;
   PC_t  [1:0]  in_source_pc;
   PC_t  [1:0]  in_target_pc;
   logic [1:0]  in_taken;
   logic        in_ready;
   logic        upd_hold;
   logic [1:0]  upd_valid;
   PC_t  [1:0]  upd_source_pc;
   PC_t  [1:0]  upd_target_pc;
   logic [1:0]  upd_taken;
   logic [3:0]  count;
   logic [15:0] conflict_stalls;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   br_update_scheduler #(.WAY(2), .DEPTH(8), .UPD_WIDTH(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_source_pc    (in_source_pc),
      .in_target_pc    (in_target_pc),
      .in_taken        (in_taken),
      .in_ready        (in_ready),
      .upd_hold        (upd_hold),
      .upd_valid       (upd_valid),
      .upd_source_pc   (upd_source_pc),
      .upd_target_pc   (upd_target_pc),
      .upd_taken       (upd_taken),
      .count           (count),
      .conflict_stalls (conflict_stalls)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input PC_t pc0, input PC_t pc1);
      in_valid        = v;
      in_source_pc[0] = pc0;
      in_source_pc[1] = pc1;
      in_target_pc[0] = pc0 + 32'h1000;
      in_target_pc[1] = pc1 + 32'h1000;
      in_taken        = {pc1[3], pc0[3]};
   endtask

   task automatic test_reset();
      reset = 1'b1; upd_hold = 1'b0; drive(2'b00, '0, '0);
      step();
      total++; if (upd_valid !== 2'b00) $display("FAIL rst_upd_valid got %b exp 00", upd_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++;
      step();
      reset = 1'b0;
      total++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
      total++; if (conflict_stalls !== 16'd0) $display("FAIL rst_stalls got %0d exp 0", conflict_stalls); else passed++;
   endtask

   task automatic test_basic();
      drive(2'b11, 32'h100, 32'h108);
      step();
      drive(2'b00, '0, '0);
      total++; if (count !== 4'd2) $display("FAIL basic_count got %0d exp 2", count); else passed++;
      total++; if (upd_valid !== 2'b11) $display("FAIL basic_valid got %b exp 11", upd_valid); else passed++;
      total++; if (upd_source_pc[0] !== 32'h100 || upd_source_pc[1] !== 32'h108)
         $display("FAIL basic_order got %h,%h exp 100,108", upd_source_pc[0], upd_source_pc[1]); else passed++;
      total++; if (upd_target_pc[1] !== 32'h1108 || upd_taken !== 2'b10)
         $display("FAIL basic_payload got %h/%b exp 1108/10", upd_target_pc[1], upd_taken); else passed++;
      step();
      total++; if (count !== 4'd0 || upd_valid !== 2'b00)
         $display("FAIL basic_drained got count=%0d valid=%b exp 0/00", count, upd_valid); else passed++;
   endtask

   task automatic test_compact();
      drive(2'b10, 32'h1F0, 32'h200);
      step();
      drive(2'b00, '0, '0);
      total++; if (count !== 4'd1) $display("FAIL compact_count got %0d exp 1", count); else passed++;
      total++; if (upd_valid !== 2'b01 || upd_source_pc[0] !== 32'h200)
         $display("FAIL compact_slot0 got %b/%h exp 01/200", upd_valid, upd_source_pc[0]); else passed++;
      step();
      total++; if (count !== 4'd0) $display("FAIL compact_drain got %0d exp 0", count); else passed++;
   endtask

   task automatic test_conflict();
      drive(2'b11, 32'h0, 32'h10);
      step();
      drive(2'b00, '0, '0);
      total++; if (upd_valid !== 2'b01 || upd_source_pc[0] !== 32'h0)
         $display("FAIL conflict_first got %b/%h exp 01/0", upd_valid, upd_source_pc[0]); else passed++;
      step();
      total++; if (upd_valid !== 2'b01 || upd_source_pc[0] !== 32'h10)
         $display("FAIL conflict_second got %b/%h exp 01/10", upd_valid, upd_source_pc[0]); else passed++;
      total++; if (conflict_stalls !== 16'd1) $display("FAIL conflict_stalls got %0d exp 1", conflict_stalls); else passed++;
      step();
      total++; if (count !== 4'd0 || conflict_stalls !== 16'd1)
         $display("FAIL conflict_end got count=%0d stalls=%0d exp 0/1", count, conflict_stalls); else passed++;
   endtask

   task automatic test_hold_full();
      upd_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 32'h400 + 32'(2*i), 32'h401 + 32'(2*i));
         step();
         total++; if (upd_valid !== 2'b00) $display("FAIL hold_valid cyc%0d got %b exp 00", i, upd_valid); else passed++;
      end
      total++; if (count !== 4'd8 || in_ready !== 1'b0)
         $display("FAIL hold_full got count=%0d ready=%b exp 8/0", count, in_ready); else passed++;
      drive(2'b11, 32'hBAD0, 32'hBAD1);
      step();
      total++; if (count !== 4'd8) $display("FAIL hold_drop got %0d exp 8", count); else passed++;
      drive(2'b00, '0, '0);
      upd_hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++; if (upd_valid !== 2'b11 || upd_source_pc[0] !== 32'h400 + 32'(2*i) || upd_source_pc[1] !== 32'h401 + 32'(2*i))
            $display("FAIL hold_drain cyc%0d got %b %h,%h exp 11 %h,%h", i, upd_valid,
                     upd_source_pc[0], upd_source_pc[1], 32'h400 + 32'(2*i), 32'h401 + 32'(2*i));
         else passed++;
         step();
      end
      total++; if (count !== 4'd0) $display("FAIL hold_empty got %0d exp 0", count); else passed++;
   endtask

   // head/tail sit at 5 here; two single enqueues move tail to 7 before the wrapping pair
   task automatic test_wrap();
      for (int i = 0; i < 2; i++) begin
         drive(2'b01, 32'h600 + 32'(i), '0);
         step();
         drive(2'b00, '0, '0);
         step();
      end
      drive(2'b11, 32'h500, 32'h508);
      step();
      drive(2'b00, '0, '0);
      total++; if (upd_valid !== 2'b11 || upd_source_pc[0] !== 32'h500 || upd_source_pc[1] !== 32'h508)
         $display("FAIL wrap_order got %b %h,%h exp 11 500,508", upd_valid, upd_source_pc[0], upd_source_pc[1]); else passed++;
      step();
      total++; if (count !== 4'd0) $display("FAIL wrap_empty got %0d exp 0", count); else passed++;
   endtask

   task automatic test_reset_mid();
      upd_hold = 1'b1;
      drive(2'b11, 32'h700, 32'h701); step();
      drive(2'b11, 32'h702, 32'h703); step();
      drive(2'b01, 32'h704, '0);      step();
      drive(2'b00, '0, '0);
      total++; if (count !== 4'd5) $display("FAIL mid_count got %0d exp 5", count); else passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      upd_hold = 1'b0;
      #1;
      total++; if (count !== 4'd0 || upd_valid !== 2'b00 || in_ready !== 1'b1)
         $display("FAIL mid_reset got count=%0d valid=%b ready=%b exp 0/00/1", count, upd_valid, in_ready); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (upd_valid !== 2'b00) $display("FAIL mid_ghost cyc%0d got %b exp 00", i, upd_valid); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_compact();
      test_conflict();
      test_hold_full();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
